moon_motion_sequencer: RTL
==========================

Name: moon_motion_sequencer

Overview:
- Sequences the moon boss movement as a repeating cycle: load home position, hold, aim at player, dash, rest, aim again.
- Sits between the game-state logic and the moon position datapath.
- Owns the movement tick divider, the phase state machine and the per-step direction commands.
- The datapath only applies single-pixel steps and home loads issued by this block.

Parameters:
- TIME_MAX, 2000000: base tick period in clk cycles before speed_offset is applied.
- MAX_X, 384: rightmost legal moon_x.
- MAX_Y, 448: bottom legal moon_y.
- HOME_X, 192: x written on home load.
- HOME_Y, 100: y written on home load.
- START_TICKS, 200: ticks held in HOME before the first aim.
- DASH_TICKS, 128: maximum steps per dash.
- REST_TICKS, 64: ticks spent in REST between dashes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  game running; low freezes the block
- speed_offset  in  26  subtracted from TIME_MAX to shorten the tick period
- player_x  in  10  player centre x
- player_y  in  10  player centre y
- moon_x  in  10  current moon x from datapath
- moon_y  in  10  current moon y from datapath
- pos_load  out  1  one-cycle pulse: datapath loads load_x/load_y
- load_x  out  10  constant HOME_X
- load_y  out  10  constant HOME_Y
- step_valid  out  1  one-cycle pulse: datapath adds step_x/step_y
- step_x  out  2  signed step: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0
- step_y  out  2  signed step, same encoding as step_x
- phase  out  2  HOME=0, AIM=1, DASH=2, REST=3
- tick  out  1  divider tick, one cycle wide

Behaviour:
- Reset values: state HOME, divider count 0, all counters 0, step_x/step_y 0, step_valid 0, tick 0, phase 0. pos_load is 1 in the first cycle after reset deasserts, otherwise 0.
- Reset mid-operation aborts immediately to the reset values. No step is issued in the reset cycle.
- Divider period: P = TIME_MAX - speed_offset, clamped to 1 when speed_offset >= TIME_MAX.
- Divider counting: count increments while enable=1. When count == P, tick=1 (registered, same cycle as the compare) and count returns to 0. enable=0 holds count.
- Divider period change: if P changes while count > P, count returns to 0 on the next enabled cycle with no tick.
- All state transitions and steps happen only on tick cycles. step_valid is registered: it is high the cycle after the tick that produced it. With enable=0, no ticks and no steps occur.
- HOME: pos_load is issued once on entry. A tick counter runs. On the START_TICKS-th tick, go to AIM.
- AIM (one tick):
  - Latch dx = player_x - moon_x and dy = player_y - moon_y as 11-bit signed values.
  - step_x = sign(dx), with 0 when dx=0; step_y likewise.
  - If both steps are 0, go to REST. Otherwise load the dash budget with DASH_TICKS and go to DASH.
  - No step is issued in AIM.
- DASH, each tick:
  - Axis clip: step_x is forced to 0 if (moon_x==0 and step_x=-1) or (moon_x>=MAX_X and step_x=+1). step_y likewise against 0/MAX_Y.
  - If both steps are 0 after clipping, go to REST with no step.
  - Otherwise pulse step_valid with the clipped steps and decrement the budget. When the budget reaches 0, go to REST.
  - Direction stays latched for the whole dash; player movement is ignored until the next AIM.
- REST: counts REST_TICKS ticks, then goes to AIM.
- phase reflects the current state combinationally from the state register.
- Only one tick source exists. Ticks and reset cannot overlap because reset has priority.

Test Plan:
- Period and home load: TIME_MAX=10, speed_offset=0, START_TICKS=2. Release reset → pos_load high exactly 1 cycle with load 192/100. tick every 11 cycles. phase becomes 1 after the 2nd tick.
- Dash toward player: moon 192/100, player 200/90, DASH_TICKS=4 → after AIM, 4 step_valid pulses, each with step_x=+1 (01) and step_y=-1 (11), spaced one tick apart. Then phase=3.
- Border clip: moon_x=0, player_x=0, moon_y=50, player_y=100 → step_x=0 and step_y=+1 on every step. With moon_x=1, player_x=0 and the datapath honouring steps → one step_x=-1 step, then step_x=0 while step_y continues. If both axes clip, go to REST with no step.
- Zero delta: player position equal to moon position at AIM → no step_valid, REST entered on that tick, AIM again after REST_TICKS ticks.
- Enable and speed: enable=0 for 50 cycles mid-DASH → no ticks, no steps, count held. speed_offset=TIME_MAX+5 → tick every 2 cycles (period clamped to 1).
- Reset mid-dash: assert reset for 1 cycle during DASH → step_valid 0 in the reset cycle. pos_load pulses after release. phase=0 and HOME restarts a full START_TICKS hold.

Source files
------------

// File: rtl/moon_motion_sequencer.sv
// Moon boss movement sequencer: tick divider plus a HOME/AIM/DASH/REST phase machine.
// It issues the home-load pulse and the single-pixel step commands to the position datapath.
module moon_motion_sequencer #(
  parameter int TIME_MAX    = 2000000,
  parameter int MAX_X       = 384,
  parameter int MAX_Y       = 448,
  parameter int HOME_X      = 192,
  parameter int HOME_Y      = 100,
  parameter int START_TICKS = 200,
  parameter int DASH_TICKS  = 128,
  parameter int REST_TICKS  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [25:0] speed_offset,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  moon_x,
  input  logic [9:0]  moon_y,
  output logic        pos_load,
  output logic [9:0]  load_x,
  output logic [9:0]  load_y,
  output logic        step_valid,
  output logic [1:0]  step_x,
  output logic [1:0]  step_y,
  output logic [1:0]  phase,
  output logic        tick
);

  typedef enum logic [1:0] {
    S_HOME = 2'd0,
    S_AIM  = 2'd1,
    S_DASH = 2'd2,
    S_REST = 2'd3
  } state_t;

  localparam logic [25:0] TIME_MAX_W = 26'(TIME_MAX);
  localparam logic [1:0]  STEP_POS   = 2'b01;
  localparam logic [1:0]  STEP_NEG   = 2'b11;
  localparam logic [1:0]  STEP_ZERO  = 2'b00;

  function automatic logic [1:0] sign_of(input logic [10:0] d);
    if (d == 11'd0)  return STEP_ZERO;
    else if (d[10])  return STEP_NEG;
    else             return STEP_POS;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [25:0] w_period;
  logic [25:0] r_count;
  logic        r_tick;
  logic        w_tick;
  logic [15:0] r_cnt;
  logic [15:0] r_budget;
  logic [1:0]  r_dir_x;
  logic [1:0]  r_dir_y;
  logic [1:0]  r_step_x;
  logic [1:0]  r_step_y;
  logic        r_step_valid;
  logic        r_first;
  logic        r_pos_load;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [1:0]  w_aim_x;
  logic [1:0]  w_aim_y;
  logic [1:0]  w_clip_x;
  logic [1:0]  w_clip_y;
  logic        w_move;

  // A speed offset at or beyond TIME_MAX would give a zero or wrapped period.
  assign w_period = (speed_offset >= TIME_MAX_W) ? 26'd1 : (TIME_MAX_W - speed_offset);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 26'd0;
      r_tick  <= 1'b0;
    end else if (enable) begin
      if (r_count == w_period) begin
        r_count <= 26'd0;
        r_tick  <= 1'b1;
      end else if (r_count > w_period) begin
        r_count <= 26'd0;
        r_tick  <= 1'b0;
      end else begin
        r_count <= r_count + 26'd1;
        r_tick  <= 1'b0;
      end
    end
  end

  // A tick pending when enable drops is held and fires once the game resumes.
  assign w_tick = r_tick & enable;

  assign w_dx    = {1'b0, player_x} - {1'b0, moon_x};
  assign w_dy    = {1'b0, player_y} - {1'b0, moon_y};
  assign w_aim_x = sign_of(w_dx);
  assign w_aim_y = sign_of(w_dy);

  assign w_clip_x = (((moon_x == 10'd0) && (r_dir_x == STEP_NEG)) ||
                     ((moon_x >= 10'(MAX_X)) && (r_dir_x == STEP_POS))) ? STEP_ZERO : r_dir_x;
  assign w_clip_y = (((moon_y == 10'd0) && (r_dir_y == STEP_NEG)) ||
                     ((moon_y >= 10'(MAX_Y)) && (r_dir_y == STEP_POS))) ? STEP_ZERO : r_dir_y;
  assign w_move   = (w_clip_x != STEP_ZERO) || (w_clip_y != STEP_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HOME;
    else       r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this combinational block free of latches.
  always_comb begin
    w_next_state = r_state;
    if (w_tick) begin
      case (r_state)
        S_HOME: if (r_cnt == 16'(START_TICKS - 1)) w_next_state = S_AIM;
        S_AIM:  w_next_state = ((w_aim_x == STEP_ZERO) && (w_aim_y == STEP_ZERO)) ? S_REST : S_DASH;
        S_DASH: if (!w_move || (r_budget == 16'd1)) w_next_state = S_REST;
        S_REST: if (r_cnt == 16'(REST_TICKS - 1)) w_next_state = S_AIM;
        default: w_next_state = S_HOME;
      endcase
    end
  end

  always_comb begin
    phase      = r_state;
    pos_load   = r_pos_load;
    load_x     = 10'(HOME_X);
    load_y     = 10'(HOME_Y);
    step_valid = r_step_valid;
    step_x     = r_step_x;
    step_y     = r_step_y;
    tick       = w_tick;
  end

  // r_first marks the first clocked cycle out of reset, which is the only HOME entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= 16'd0;
      r_budget     <= 16'd0;
      r_dir_x      <= STEP_ZERO;
      r_dir_y      <= STEP_ZERO;
      r_step_x     <= STEP_ZERO;
      r_step_y     <= STEP_ZERO;
      r_step_valid <= 1'b0;
      r_first      <= 1'b1;
      r_pos_load   <= 1'b0;
    end else begin
      r_first      <= 1'b0;
      r_pos_load   <= r_first;
      r_step_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_HOME: r_cnt <= (w_next_state == S_AIM) ? 16'd0 : r_cnt + 16'd1;
          S_AIM: begin
            r_dir_x  <= w_aim_x;
            r_dir_y  <= w_aim_y;
            r_step_x <= w_aim_x;
            r_step_y <= w_aim_y;
            r_budget <= 16'(DASH_TICKS);
            r_cnt    <= 16'd0;
          end
          S_DASH: begin
            r_cnt <= 16'd0;
            if (w_move) begin
              r_step_valid <= 1'b1;
              r_step_x     <= w_clip_x;
              r_step_y     <= w_clip_y;
              r_budget     <= r_budget - 16'd1;
            end
          end
          S_REST: r_cnt <= (w_next_state == S_AIM) ? 16'd0 : r_cnt + 16'd1;
          default: r_cnt <= 16'd0;
        endcase
      end
    end
  end

endmodule
